// File: rtl/yin_tau_sweeper_pkg.sv
// Shared widths, constants and FSM encoding for the YIN lag sweeper.
// Product widths are derived here so the comparator and the top agree on them.
package yin_tau_sweeper_pkg;

    localparam int ACC_WIDTH   = 39;
    localparam int TAU_WIDTH   = 6;
    localparam int MAX_TAU     = 40;
    localparam int TIMEOUT_CYC = 1024;
    localparam logic [7:0] THRESH_Q8 = 8'd38;

    localparam int SUM_WIDTH   = ACC_WIDTH + TAU_WIDTH;
    localparam int THR_WIDTH   = SUM_WIDTH + 8;
    localparam int CROSS_WIDTH = 2 * SUM_WIDTH;
    localparam int CNT_WIDTH   = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_EVAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/yin_tau_sweeper_if.sv
// Lag/restart/ready handshake between the sweeper (master) and diff_module (slave).
interface yin_tau_sweeper_if;
    import yin_tau_sweeper_pkg::*;

    logic [TAU_WIDTH-1:0] diff_tau;
    logic                 diff_reset;
    logic                 diff_ready;
    logic [ACC_WIDTH-1:0] diff_acc;

    modport master (
        output diff_tau,
        output diff_reset,
        input  diff_ready,
        input  diff_acc
    );

    modport slave (
        input  diff_tau,
        input  diff_reset,
        output diff_ready,
        output diff_acc
    );

endinterface

// File: rtl/yin_tau_sweeper_cmndf_compare.sv
// Division-free CMNDF tests: d*tau/cumsum against the threshold and against the stored best.
// A zero cumsum means CMNDF = 1, so it is never below and never beats the best.
module cmndf_compare
    import yin_tau_sweeper_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] d,
    input  logic [TAU_WIDTH-1:0] tau,
    input  logic [SUM_WIDTH-1:0] cumsum,
    input  logic [7:0]           thresh,
    input  logic [ACC_WIDTH-1:0] best_d,
    input  logic [TAU_WIDTH-1:0] best_tau,
    input  logic [SUM_WIDTH-1:0] best_cumsum,
    output logic                 below,
    output logic                 better
);

    logic [SUM_WIDTH-1:0]   cur_num;
    logic [SUM_WIDTH-1:0]   best_num;
    logic [THR_WIDTH-1:0]   lhs_thr;
    logic [THR_WIDTH-1:0]   rhs_thr;
    logic [CROSS_WIDTH-1:0] lhs_cross;
    logic [CROSS_WIDTH-1:0] rhs_cross;

    always_comb begin
        cur_num   = SUM_WIDTH'(d) * SUM_WIDTH'(tau);
        best_num  = SUM_WIDTH'(best_d) * SUM_WIDTH'(best_tau);
        lhs_thr   = {cur_num, 8'd0};
        rhs_thr   = THR_WIDTH'(thresh) * THR_WIDTH'(cumsum);
        lhs_cross = CROSS_WIDTH'(cur_num) * CROSS_WIDTH'(best_cumsum);
        rhs_cross = CROSS_WIDTH'(best_num) * CROSS_WIDTH'(cumsum);
        below     = (cumsum != '0) && (lhs_thr < rhs_thr);
        // An empty best (cumsum 0) is beaten by any valid candidate; ties keep the earlier lag.
        better    = (cumsum != '0) && ((best_cumsum == '0) || (lhs_cross < rhs_cross));
    end

endmodule

// File: rtl/yin_tau_sweeper.sv
// Drives diff_module through tau = 1..MAX_TAU, accumulates the CMNDF denominator and
// selects the pitch lag by absolute threshold, falling back to the global minimum.
module yin_tau_sweeper
    import yin_tau_sweeper_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    yin_tau_sweeper_if.master    diff,
    output logic                 busy,
    output logic                 done,
    output logic [TAU_WIDTH-1:0] tau_est,
    output logic                 found,
    output logic                 timeout
);

    state_t               state_reg;
    logic [SUM_WIDTH-1:0] cumsum_reg;
    logic [SUM_WIDTH-1:0] cumsum_next;
    logic [SUM_WIDTH-1:0] best_cumsum_reg;
    logic [ACC_WIDTH-1:0] d_reg;
    logic [ACC_WIDTH-1:0] best_d_reg;
    logic [TAU_WIDTH-1:0] best_tau_reg;
    logic [TAU_WIDTH-1:0] best_tau_next;
    logic                 crossed_reg;
    logic                 crossed_next;
    logic                 armed_reg;
    logic [CNT_WIDTH-1:0] wait_cnt_reg;
    logic                 below;
    logic                 better;
    logic                 take_best;
    logic                 stop_sweep;

    cmndf_compare u_cmp (
        .d           (d_reg),
        .tau         (diff.diff_tau),
        .cumsum      (cumsum_next),
        .thresh      (THRESH_Q8),
        .best_d      (best_d_reg),
        .best_tau    (best_tau_reg),
        .best_cumsum (best_cumsum_reg),
        .below       (below),
        .better      (better)
    );

    // Before the first crossing the best tracks the global minimum; after it, the first rise ends the dip.
    always_comb begin
        cumsum_next   = cumsum_reg + SUM_WIDTH'(d_reg);
        take_best     = crossed_reg ? better : (below || better);
        stop_sweep    = (crossed_reg && !better) || (diff.diff_tau == TAU_WIDTH'(MAX_TAU));
        best_tau_next = take_best ? diff.diff_tau : best_tau_reg;
        crossed_next  = crossed_reg || below;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            diff.diff_tau   <= '0;
            diff.diff_reset <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            tau_est         <= '0;
            found           <= 1'b0;
            timeout         <= 1'b0;
            cumsum_reg      <= '0;
            best_cumsum_reg <= '0;
            d_reg           <= '0;
            best_d_reg      <= '0;
            best_tau_reg    <= '0;
            crossed_reg     <= 1'b0;
            armed_reg       <= 1'b0;
            wait_cnt_reg    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    diff.diff_reset <= 1'b1;
                    if (start) begin
                        cumsum_reg      <= '0;
                        best_cumsum_reg <= '0;
                        best_d_reg      <= '0;
                        best_tau_reg    <= '0;
                        crossed_reg     <= 1'b0;
                        timeout         <= 1'b0;
                        tau_est         <= '0;
                        found           <= 1'b0;
                        diff.diff_tau   <= TAU_WIDTH'(1);
                        busy            <= 1'b1;
                        state_reg       <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    diff.diff_reset <= 1'b0;
                    armed_reg       <= 1'b0;
                    wait_cnt_reg    <= '0;
                    state_reg       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A ready left over from the previous lag only counts after a low has been seen.
                    if (!diff.diff_ready) begin
                        armed_reg <= 1'b1;
                    end
                    if (armed_reg && diff.diff_ready) begin
                        d_reg     <= diff.diff_acc;
                        state_reg <= ST_EVAL;
                    end else if (wait_cnt_reg == CNT_WIDTH'(TIMEOUT_CYC - 1)) begin
                        timeout         <= 1'b1;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        diff.diff_reset <= 1'b1;
                        tau_est         <= best_tau_reg;
                        found           <= crossed_reg;
                        state_reg       <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_WIDTH'(1);
                    end
                end
                ST_EVAL: begin
                    cumsum_reg  <= cumsum_next;
                    crossed_reg <= crossed_next;
                    if (take_best) begin
                        best_d_reg      <= d_reg;
                        best_tau_reg    <= diff.diff_tau;
                        best_cumsum_reg <= cumsum_next;
                    end
                    diff.diff_reset <= 1'b1;
                    if (stop_sweep) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        tau_est   <= best_tau_next;
                        found     <= crossed_next;
                        state_reg <= ST_DONE;
                    end else begin
                        diff.diff_tau <= diff.diff_tau + TAU_WIDTH'(1);
                        state_reg     <= ST_ARM;
                    end
                end
                ST_DONE: begin
                    diff.diff_reset <= 1'b1;
                    state_reg       <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yin_tau_sweeper.sv
// Directed bench for yin_tau_sweeper with a behavioural diff_module stand-in driving hand-computed d(tau).
module tb_yin_tau_sweeper;
    import yin_tau_sweeper_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [TAU_WIDTH-1:0] tau_est;
    logic                 found;
    logic                 timeout;

    yin_tau_sweeper_if dif ();

    yin_tau_sweeper dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .diff    (dif),
        .busy    (busy),
        .done    (done),
        .tau_est (tau_est),
        .found   (found),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_mode   = 0;   // 0 normal, 1 never ready at tau 3, 2 stale ready across ARM
    int model_pat    = 0;   // 0 flat 1000 with dip at 10, 1 period-20 waveform, 2 silence
    int lat          = 0;
    int cyc          = 0;
    int done_count   = 0;
    int rst_fall_cyc = 0;
    int done_cyc     = 0;
    logic last_rst   = 1'b1;
    int tau_seq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    // d(tau) for a 100 Hz tone at FS=2000: 10000*(1-cos(2*pi*tau/20)), rounded.
    function automatic logic [ACC_WIDTH-1:0] d_of(input int pat, input int tau);
        int k;
        k = tau % 20;
        case (pat)
            0: return (tau == 10) ? ACC_WIDTH'(10) : ACC_WIDTH'(1000);
            1: begin
                case (k)
                    0:       return ACC_WIDTH'(0);
                    1, 19:   return ACC_WIDTH'(489);
                    2, 18:   return ACC_WIDTH'(1910);
                    3, 17:   return ACC_WIDTH'(4122);
                    4, 16:   return ACC_WIDTH'(6910);
                    5, 15:   return ACC_WIDTH'(10000);
                    6, 14:   return ACC_WIDTH'(13090);
                    7, 13:   return ACC_WIDTH'(15878);
                    8, 12:   return ACC_WIDTH'(18090);
                    9, 11:   return ACC_WIDTH'(19511);
                    default: return ACC_WIDTH'(20000);
                endcase
            end
            default: return '0;
        endcase
    endfunction

    // diff_module stand-in: result appears a few cycles after restart is released.
    always @(posedge clk) begin
        if (reset || dif.diff_reset) begin
            lat            <= 0;
            dif.diff_ready <= (model_mode == 2);
            dif.diff_acc   <= '0;
        end else begin
            lat <= lat + 1;
            if (model_mode == 1 && dif.diff_tau == TAU_WIDTH'(3)) begin
                dif.diff_ready <= 1'b0;
            end else if (model_mode == 2) begin
                if (lat == 0) begin
                    dif.diff_ready <= 1'b1;
                    dif.diff_acc   <= '0;
                end else if (lat < 6) begin
                    dif.diff_ready <= 1'b0;
                end else begin
                    dif.diff_ready <= 1'b1;
                    dif.diff_acc   <= d_of(model_pat, int'(dif.diff_tau));
                end
            end else if (lat >= 3) begin
                dif.diff_ready <= 1'b1;
                dif.diff_acc   <= d_of(model_pat, int'(dif.diff_tau));
            end else begin
                dif.diff_ready <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (last_rst && !dif.diff_reset) begin
            tau_seq.push_back(int'(dif.diff_tau));
            rst_fall_cyc = cyc;
        end
        last_rst = dif.diff_reset;
        if (done) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
        end
    end

    task automatic run_sweep(input int poke_at, output bit got_done);
        tau_seq.delete();
        done_count = 0;
        got_done   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
            start = (i == poke_at);
        end
        start = 1'b0;
        if (!got_done) check("done_wait", 64'd0, 64'd1);
    endtask

    // Called in the DONE cycle; also pulses start there, which must be ignored.
    task automatic finish_checks(input string name, input int exp_tau, input int exp_found,
                                 input int exp_to, input int exp_len);
        int viol;
        check({name, "_tau_est"}, 64'(tau_est), 64'(exp_tau));
        check({name, "_found"}, 64'(found), 64'(exp_found));
        check({name, "_timeout"}, 64'(timeout), 64'(exp_to));
        check({name, "_busy_done"}, 64'(busy), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        check({name, "_no_restart"}, 64'(busy), 64'd0);
        check({name, "_done_count"}, 64'(done_count), 64'd1);
        check({name, "_tau_seq_len"}, 64'(tau_seq.size()), 64'(exp_len));
        viol = 0;
        foreach (tau_seq[i]) if (tau_seq[i] != i + 1) viol++;
        check({name, "_tau_seq_order"}, 64'(viol), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;

        repeat (3) @(negedge clk);
        check("rst_diff_reset", 64'(dif.diff_reset), 64'd1);
        check("rst_diff_tau", 64'(dif.diff_tau), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tau_est", 64'(tau_est), 64'd0);
        check("rst_found", 64'(found), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Dip at tau 10: crossing there, rise at 11 ends the sweep.
        model_mode = 0; model_pat = 0;
        run_sweep(-1, got);
        if (got) finish_checks("dip", 10, 1, 0, 11);

        // Period-20 tone: crosses at 19, minimum at 20, rise at 21.
        model_mode = 0; model_pat = 1;
        run_sweep(-1, got);
        if (got) finish_checks("tone", 20, 1, 0, 21);

        // Silence: every CMNDF is 1, full sweep, no best.
        model_mode = 0; model_pat = 2;
        run_sweep(-1, got);
        if (got) finish_checks("silence", 0, 0, 0, MAX_TAU);

        // No ready at tau 3: abort after the wait budget, best so far is tau 1.
        model_mode = 1; model_pat = 0;
        run_sweep(-1, got);
        if (got) begin
            finish_checks("tmo", 1, 0, 1, 3);
            check("tmo_wait_cycles", 64'(done_cyc - rst_fall_cyc), 64'(TIMEOUT_CYC));
        end

        // Stale ready across ARM must be skipped; start during busy must not restart.
        model_mode = 2; model_pat = 0;
        run_sweep(20, got);
        if (got) finish_checks("stale", 10, 1, 0, 11);

        // Asynchronous reset while waiting at tau 7.
        model_mode = 0; model_pat = 0;
        tau_seq.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (dif.diff_tau == TAU_WIDTH'(7) && !dif.diff_reset) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("rst_mid_wait_reach", 64'd0, 64'd1);
        done_count = 0;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_diff_reset", 64'(dif.diff_reset), 64'd1);
        check("rst_mid_diff_tau", 64'(dif.diff_tau), 64'd0);
        check("rst_mid_tau_est", 64'(tau_est), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 64'(done_count), 64'd0);
        check("rst_mid_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
